// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared types and helpers for the store buffer.
//   WORD_W   - data/address word width (32)
//   BYTE_OFS - number of byte-offset bits dropped from a byte address (2)
//   IDX_W    - widest possible word index (WORD_W - BYTE_OFS)
//   sb_entry_t  - one buffered store {idx, data}
//   word_index  - byte address -> word index limited to 'aw' bits
package store_buffer_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BYTE_OFS = 2;
  localparam int unsigned IDX_W    = WORD_W - BYTE_OFS;

  // idx is held zero-extended to IDX_W so that {idx, 2'b00} is the memory
  // byte address directly; only the low AW bits are ever non-zero.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
  } sb_entry_t;

  // Word index addr[aw+1:2], zero-extended; upper address bits are ignored.
  function automatic logic [IDX_W-1:0] word_index(input logic [WORD_W-1:0] addr,
                                                  input int unsigned      aw);
    logic [IDX_W-1:0] mask;
    mask = (IDX_W'(1) << aw) - IDX_W'(1);
    return IDX_W'(addr >> BYTE_OFS) & mask;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_match.sv
// sb_fwd_match: store-to-load forwarding lookup.
//   entries_i - buffered entries (circular array)
//   valid_i   - per-slot valid bits
//   tail_i    - next write slot; tail-1 is the youngest entry
//   ld_idx_i  - word index of the load
//   hit_o     - some valid entry matches ld_idx_i
//   data_o    - data of the youngest matching entry, 0 on miss
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [PW-1:0]         tail_i,
  input  logic [IDX_W-1:0]      ld_idx_i,
  output logic                  hit_o,
  output logic [WORD_W-1:0]     data_o
);

  // Walk slots oldest-to-youngest (tail-DEPTH .. tail-1); a later match
  // overrides an earlier one, so the youngest match wins.
  always_comb begin
    logic [PW-1:0] slot;
    hit_o  = 1'b0;
    data_o = '0;
    slot   = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      slot = tail_i - PW'(k);
      if (valid_i[slot] && (entries_i[slot].idx == ld_idx_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[slot].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the store path and data memory,
// with youngest-match forwarding to loads.
//   clock, reset_n         - clock, async active-low reset
//   st_valid/st_addr/st_data/st_ready - store push handshake
//   ld_addr, ld_hit, ld_data - load forwarding lookup (combinational)
//   mem_we/mem_addr/mem_wdata/mem_ready - drain handshake to memory
//   count, empty, full     - occupancy
// Optional feature macro STORE_BUF_COALESCE_EN: a store to the same word
// as the youngest entry overwrites it in place instead of allocating.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 10
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       st_valid,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  output logic                       st_ready,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hit,
  output logic [31:0]                ld_data,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic [IDX_W-1:0] st_idx;
  logic [IDX_W-1:0] ld_idx;
  logic             pop;
  logic             push;
  logic             coalesce;

  assign st_idx = word_index(st_addr, AW);
  assign ld_idx = word_index(ld_addr, AW);

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign mem_we    = !empty;
  // Popped slots are cleared, so an empty buffer presents zero here.
  assign mem_addr  = {entries_q[head_q].idx, 2'b00};
  assign mem_wdata = entries_q[head_q].data;
  assign pop       = mem_we && mem_ready;

`ifdef STORE_BUF_COALESCE_EN
  logic [PW-1:0] young;
  logic          young_match;

  assign young       = tail_q - PW'(1);
  assign young_match = valid_q[young] && (entries_q[young].idx == st_idx);
  // When full the youngest slot is never the head, so st_ready stays
  // independent of mem_ready; the pop check only matters at count==1.
  assign st_ready    = !full || young_match;
  assign coalesce    = st_valid && young_match && !((young == head_q) && pop);
`else
  assign st_ready    = !full;
  assign coalesce    = 1'b0;
`endif

  assign push = st_valid && st_ready && !coalesce;

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (pop) begin
      entries_d[head_q] = '0;
      valid_d[head_q]   = 1'b0;
      head_d            = head_q + PW'(1);
    end
    // A push never targets the popping head: tail==head only when empty
    // (no pop) or full (no allocating push).
    if (push) begin
      entries_d[tail_q].idx  = st_idx;
      entries_d[tail_q].data = st_data;
      valid_d[tail_q]        = 1'b1;
      tail_d                 = tail_q + PW'(1);
    end
`ifdef STORE_BUF_COALESCE_EN
    if (coalesce) begin
      entries_d[young].data = st_data;
    end
`endif

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entries_q <= '0;
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .tail_i    (tail_q),
    .ld_idx_i  (ld_idx),
    .hit_o     (ld_hit),
    .data_o    (ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed + random stimulus for store_buffer, checked each
// cycle against a queue-based reference model of the buffer contents.
// Honours STORE_BUF_COALESCE_EN the same way the design does.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned CW    = $clog2(DEPTH+1);
`ifdef STORE_BUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          st_ready;
  logic [31:0]   ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  always #5 clock = ~clock;

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  int unsigned compared = 0;
  int unsigned mism     = 0;

  // Reference model: oldest entry at [0], youngest at the back.
  logic [31:0] qidx[$];
  logic [31:0] qdat[$];

  function automatic logic [31:0] idx_of(input logic [31:0] a);
    return (a >> 2) & ((32'd1 << AW) - 32'd1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs before the edge, then
  // advance the model by the handshakes the model itself predicts.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic mr, input logic [31:0] la);
    int unsigned n;
    bit          e_ready, e_hit, popm, acc, coal, ymatch;
    logic [31:0] e_ld, e_addr, e_data;
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    mem_ready = mr;
    ld_addr   = la;
    #3;
    n       = qidx.size();
    ymatch  = (n > 0) && (qidx[n-1] == idx_of(a));
    e_ready = (n < DEPTH) || (COAL && ymatch);
    e_hit   = 1'b0;
    e_ld    = '0;
    for (int unsigned i = 0; i < n; i++) begin
      if (qidx[i] == idx_of(la)) begin
        e_hit = 1'b1;
        e_ld  = qdat[i];
      end
    end
    e_addr = (n > 0) ? (qidx[0] << 2) : 32'd0;
    e_data = (n > 0) ? qdat[0] : 32'd0;
    chk("count",     32'(count),    n);
    chk("empty",     32'(empty),    32'(n == 0));
    chk("full",      32'(full),     32'(n == DEPTH));
    chk("st_ready",  32'(st_ready), 32'(e_ready));
    chk("mem_we",    32'(mem_we),   32'(n > 0));
    chk("mem_addr",  mem_addr,      e_addr);
    chk("mem_wdata", mem_wdata,     e_data);
    chk("ld_hit",    32'(ld_hit),   32'(e_hit));
    chk("ld_data",   ld_data,       e_ld);
    popm = (n > 0) && mr;
    acc  = v && e_ready;
    coal = acc && COAL && ymatch && !((n == 1) && popm);
    @(posedge clock);
    #1;
    if (popm) begin
      void'(qidx.pop_front());
      void'(qdat.pop_front());
    end
    if (coal) begin
      qdat[qdat.size()-1] = d;
    end else if (acc) begin
      qidx.push_back(idx_of(a));
      qdat.push_back(d);
    end
  endtask

  task automatic drain(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    mem_ready = 1'b0;
    ld_addr   = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Idle after reset
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 32'h004);

    // Two posted writes, drained in order
    step(1'b1, 32'h004, 32'h11, 1'b0, 32'h004);
    step(1'b1, 32'h008, 32'h22, 1'b0, 32'h008);
    step(1'b0, 32'h000, 32'h00, 1'b0, 32'h008);
    drain(3);

    // Fill, hold a 5th store, pop once, then accept it across the wrap
    for (int unsigned i = 0; i < DEPTH; i++)
      step(1'b1, 32'h100 + 32'(i * 4), 32'(i + 1), 1'b0, 32'h104);
    step(1'b1, 32'h110, 32'h5, 1'b0, 32'h110);
    step(1'b1, 32'h110, 32'h5, 1'b0, 32'h110);
    step(1'b1, 32'h110, 32'h5, 1'b1, 32'h110);
    step(1'b1, 32'h110, 32'h5, 1'b0, 32'h110);
    drain(DEPTH + 2);

    // Forwarding: youngest of two matches, ignoring byte offset
    step(1'b1, 32'h010, 32'hA, 1'b0, 32'h013);
    step(1'b1, 32'h010, 32'hB, 1'b0, 32'h013);
    step(1'b0, 32'h000, 32'h0, 1'b0, 32'h013);
    step(1'b0, 32'h000, 32'h0, 1'b0, 32'h014);
    step(1'b0, 32'hFFFF_F010, 32'h0, 1'b0, 32'hABCD_E012);
    drain(3);

    // Push and pop together at count==1
    step(1'b1, 32'h200, 32'h1000, 1'b0, 32'h200);
    for (int unsigned i = 0; i < 20; i++)
      step(1'b1, 32'h200 + 32'((i % 5) * 4), 32'h2000 + 32'(i), 1'b1, 32'h200);
    drain(2);

    // Async reset with entries pending mid-handshake
    for (int unsigned i = 0; i < 3; i++)
      step(1'b1, 32'h040 + 32'(i * 4), 32'h77 + 32'(i), 1'b0, 32'h040);
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    qidx.delete();
    qdat.delete();
    chk("rst_mem_we",    32'(mem_we),   32'd0);
    chk("rst_count",     32'(count),    32'd0);
    chk("rst_empty",     32'(empty),    32'd1);
    chk("rst_st_ready",  32'(st_ready), 32'd1);
    chk("rst_mem_addr",  mem_addr,      32'd0);
    chk("rst_mem_wdata", mem_wdata,     32'd0);
    chk("rst_ld_hit",    32'(ld_hit),   32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 32'h040);

    // Repeated stores to the youngest word while full
    step(1'b1, 32'h100, 32'h31, 1'b0, 32'h020);
    step(1'b1, 32'h104, 32'h32, 1'b0, 32'h020);
    step(1'b1, 32'h108, 32'h33, 1'b0, 32'h020);
    step(1'b1, 32'h020, 32'h34, 1'b0, 32'h020);
    step(1'b1, 32'h020, 32'hC1, 1'b0, 32'h020);
    step(1'b1, 32'h020, 32'hC2, 1'b0, 32'h020);
    step(1'b0, 32'h000, 32'h00, 1'b0, 32'h020);
    drain(DEPTH + 2);

    // Random traffic over a small address set, varying drain pressure
    for (int unsigned blk = 0; blk < 4; blk++) begin
      for (int unsigned i = 0; i < 100; i++) begin
        logic [31:0] a, la;
        logic        v, mr;
        a  = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 5)) << 2);
        la = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 6)) << 2);
        v  = ($urandom_range(0, 99) < 70);
        mr = ($urandom_range(0, 99) < 20 + blk * 25);
        step(v, a, $urandom(), mr, la);
      end
    end
    drain(DEPTH + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
